// File: rtl/keypad_scan_matrix.sv
// keypad_scan_matrix
//   Debounced, full-matrix keypad scanner for the coin-charger front panel.
//   Waits for any row to go low, debounces the press, scans every column once,
//   accepts the press only if exactly one key is seen, then holds that column
//   driven while emitting auto-repeat pulses, and debounces the release.
//
// Ports
//   CLK                   scan clock
//   anti_shake_cnt_reset  asynchronous, active-high reset
//   row    [ROWS]         row sense, active-low, idle all-ones
//   col    [COLS]         column drive, active-low (all low while waiting)
//   key_code [CODE_W]     row_idx*COLS + col_idx of the last accepted key;
//                         all-ones means no key since reset
//   key_valid             one-cycle pulse on acceptance of a new key
//   key_repeat            one-cycle pulse per auto-repeat event
//   key_held              high while the accepted key stays pressed
//   multi_err             one-cycle pulse when a scan sees more than one key
//   idle                  high while waiting for / debouncing a press
module keypad_scan_matrix #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int CODE_W       = 4,
  parameter int DEBOUNCE     = 31,
  parameter int REPEAT_DELAY = 1525,
  parameter int REPEAT_RATE  = 305
) (
  input  logic              CLK,
  input  logic              anti_shake_cnt_reset,
  input  logic [ROWS-1:0]   row,
  output logic [COLS-1:0]   col,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_repeat,
  output logic              key_held,
  output logic              multi_err,
  output logic              idle
);

  localparam int DB_W   = $clog2(DEBOUNCE + 1);
  localparam int PH_W   = $clog2(2 * COLS);
  localparam int RI_W   = $clog2(ROWS);
  localparam int CI_W   = $clog2(COLS);
  localparam int LOW_W  = $clog2(ROWS + 1);
  localparam int HITS_W = $clog2(ROWS * COLS + 1);
  localparam int HOLD_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

  localparam logic [DB_W-1:0]   DB_MAX     = DB_W'(DEBOUNCE);
  localparam logic [PH_W-1:0]   PH_LAST    = PH_W'(2 * COLS - 1);
  localparam logic [CI_W-1:0]   COL_TOP    = CI_W'(COLS - 1);
  localparam logic [HITS_W-1:0] HITS_ONE   = HITS_W'(1);
  localparam logic [LOW_W-1:0]  LOW_ONE    = LOW_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_FIRST = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] HOLD_WRAP  = HOLD_W'(REPEAT_DELAY + REPEAT_RATE);

  typedef enum logic [2:0] {IDLE, PRESS_CHECK, SCAN, HOLD, FREE_CHECK} state_t;

  function automatic logic [LOW_W-1:0] count_low(input logic [ROWS-1:0] r);
    logic [LOW_W-1:0] n;
    n = '0;
    for (int i = 0; i < ROWS; i++)
      if (!r[i]) n = n + LOW_ONE;
    return n;
  endfunction

  // Index of the lowest-numbered low row bit; only meaningful when one is low.
  function automatic logic [RI_W-1:0] low_index(input logic [ROWS-1:0] r);
    logic [RI_W-1:0] idx;
    idx = '0;
    for (int i = ROWS - 1; i >= 0; i--)
      if (!r[i]) idx = RI_W'(i);
    return idx;
  endfunction

  state_t              state_q, state_d;
  logic [DB_W-1:0]     db_q, db_d, db_nxt;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic [HITS_W-1:0]   hits_q, hits_d, total;
  logic [RI_W-1:0]     cap_row_q, cap_row_d, hold_row_q, hold_row_d, r_sel;
  logic [CI_W-1:0]     cap_col_q, cap_col_d, hold_col_q, hold_col_d, c_sel, scan_col;
  logic [HOLD_W-1:0]   hold_q, hold_d, hold_nxt;
  logic [LOW_W-1:0]    sample_low;
  logic [COLS-1:0]     col_d;
  logic [CODE_W-1:0]   code_d;
  logic                valid_d, repeat_d, merr_d, held_d, idle_d;

  assign sample_low = count_low(row);
  assign total      = hits_q + HITS_W'(sample_low);
  // Columns are scanned from COLS-1 down to 0, two phases (drive, sample) each.
  assign scan_col   = COL_TOP - ph_q[PH_W-1:1];
  assign db_nxt     = db_q + DB_W'(1);
  assign hold_nxt   = hold_q + HOLD_W'(1);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    db_d       = db_q;
    ph_d       = ph_q;
    hits_d     = hits_q;
    cap_row_d  = cap_row_q;
    cap_col_d  = cap_col_q;
    hold_row_d = hold_row_q;
    hold_col_d = hold_col_q;
    hold_d     = hold_q;
    code_d     = key_code;
    valid_d    = 1'b0;
    repeat_d   = 1'b0;
    merr_d     = 1'b0;
    r_sel      = cap_row_q;
    c_sel      = cap_col_q;

    unique case (state_q)
      IDLE: begin
        if (!(&row)) begin
          state_d = PRESS_CHECK;
          db_d    = DB_W'(1);
        end
      end

      PRESS_CHECK: begin
        if (&row) begin
          state_d = IDLE;
          db_d    = '0;
        end else if (db_q == DB_MAX) begin
          state_d = SCAN;
          db_d    = '0;
          ph_d    = '0;
          hits_d  = '0;
        end else begin
          db_d = db_nxt;
        end
      end

      SCAN: begin
        ph_d = ph_q + PH_W'(1);
        if (ph_q[0]) begin
          hits_d = total;
          if (sample_low == LOW_ONE) begin
            cap_row_d = low_index(row);
            cap_col_d = scan_col;
          end
        end
        // The final sample is folded in combinationally so the verdict is
        // taken on the same edge that ends the scan.
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (sample_low == LOW_ONE) begin
            r_sel = low_index(row);
            c_sel = scan_col;
          end
          if (total == HITS_ONE) begin
            state_d    = HOLD;
            hold_row_d = r_sel;
            hold_col_d = c_sel;
            hold_d     = '0;
            code_d     = CODE_W'(int'(r_sel) * COLS + int'(c_sel));
            valid_d    = 1'b1;
          end else if (total > HITS_ONE) begin
            state_d = FREE_CHECK;
            db_d    = '0;
            merr_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      HOLD: begin
        if (row[hold_row_q]) begin
          state_d = FREE_CHECK;
          db_d    = '0;
        end else if (REPEAT_DELAY > 0) begin
          // After the first repeat the counter cycles between REPEAT_DELAY
          // and REPEAT_DELAY+REPEAT_RATE, so it never overflows on long holds.
          if (hold_nxt == HOLD_WRAP) begin
            hold_d   = HOLD_FIRST;
            repeat_d = 1'b1;
          end else begin
            hold_d   = hold_nxt;
            repeat_d = (hold_nxt == HOLD_FIRST);
          end
        end
      end

      FREE_CHECK: begin
        if (!(&row)) begin
          db_d = '0;
        end else if (db_nxt == DB_MAX) begin
          state_d = IDLE;
          db_d    = '0;
        end else begin
          db_d = db_nxt;
        end
      end

      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    col_d = '0;
    if (state_d == SCAN)
      col_d = ~(COLS'(1) << (COL_TOP - ph_d[PH_W-1:1]));
    else if (state_d == HOLD)
      col_d = ~(COLS'(1) << hold_col_d);
    idle_d = (state_d == IDLE) || (state_d == PRESS_CHECK);
    held_d = (state_d == HOLD);
  end

  always_ff @(posedge CLK or posedge anti_shake_cnt_reset) begin
    if (anti_shake_cnt_reset) begin
      state_q    <= IDLE;
      db_q       <= '0;
      ph_q       <= '0;
      hits_q     <= '0;
      cap_row_q  <= '0;
      cap_col_q  <= '0;
      hold_row_q <= '0;
      hold_col_q <= '0;
      hold_q     <= '0;
      col        <= '0;
      key_code   <= '1;
      key_valid  <= 1'b0;
      key_repeat <= 1'b0;
      key_held   <= 1'b0;
      multi_err  <= 1'b0;
      idle       <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register updates from
      // pre-edge values regardless of statement order.
      state_q    <= state_d;
      db_q       <= db_d;
      ph_q       <= ph_d;
      hits_q     <= hits_d;
      cap_row_q  <= cap_row_d;
      cap_col_q  <= cap_col_d;
      hold_row_q <= hold_row_d;
      hold_col_q <= hold_col_d;
      hold_q     <= hold_d;
      col        <= col_d;
      key_code   <= code_d;
      key_valid  <= valid_d;
      key_repeat <= repeat_d;
      key_held   <= held_d;
      multi_err  <= merr_d;
      idle       <= idle_d;
    end
  end

endmodule

// File: tb/tb_keypad_scan_matrix.sv
// tb_keypad_scan_matrix
//   Scoreboard bench for keypad_scan_matrix: a default 4x4 instance and a
//   3x4 instance with auto-repeat disabled. Stimulus presses keys on a
//   behavioural keypad and pushes the pulses it expects (kind, code, and the
//   clock edge at which a downstream register would capture them); a monitor
//   pops and compares whenever a DUT raises a pulse.
module tb_keypad_scan_matrix;

  localparam int D  = 31;
  localparam int C  = 4;
  localparam int R  = 4;
  localparam int RB = 3;
  localparam int RD = 1525;
  localparam int RR = 305;

  typedef enum int {EV_VALID, EV_REPEAT, EV_MERR} ev_kind_t;
  typedef struct {
    int       dut;
    ev_kind_t kind;
    int       code;
    int       edge_n;
  } ev_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic anti_shake_cnt_reset;

  logic [R-1:0]  row_a;
  logic [C-1:0]  col_a;
  logic [3:0]    code_a;
  logic          kv_a, kr_a, kh_a, me_a, idle_a;
  logic [RB-1:0] row_b;
  logic [C-1:0]  col_b;
  logic [3:0]    code_b;
  logic          kv_b, kr_b, kh_b, me_b, idle_b;

  keypad_scan_matrix u_dut_a (
    .CLK(CLK), .anti_shake_cnt_reset(anti_shake_cnt_reset),
    .row(row_a), .col(col_a), .key_code(code_a),
    .key_valid(kv_a), .key_repeat(kr_a), .key_held(kh_a),
    .multi_err(me_a), .idle(idle_a)
  );

  keypad_scan_matrix #(.ROWS(RB), .COLS(C), .REPEAT_DELAY(0)) u_dut_b (
    .CLK(CLK), .anti_shake_cnt_reset(anti_shake_cnt_reset),
    .row(row_b), .col(col_b), .key_code(code_b),
    .key_valid(kv_b), .key_repeat(kr_b), .key_held(kh_b),
    .multi_err(me_b), .idle(idle_b)
  );

  // Physical keypad: a pressed key shorts its row to its column, so a row
  // reads low whenever any pressed key on it sits in a driven-low column.
  logic [R*C-1:0]  press_a = '0;
  logic [RB*C-1:0] press_b = '0;

  always_comb begin
    row_a = '1;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        if (press_a[r*C+c] && !col_a[c]) row_a[r] = 1'b0;
  end

  always_comb begin
    row_b = '1;
    for (int r = 0; r < RB; r++)
      for (int c = 0; c < C; c++)
        if (press_b[r*C+c] && !col_b[c]) row_b[r] = 1'b0;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int   n_cmp = 0;
  int   n_bad = 0;
  ev_t  exp_q[$];
  int   last_code_a = 15;
  bit   watch_idle = 1'b0;
  int   idle_drops = 0;

  function automatic void check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void push_ev(input int d, input ev_kind_t k, input int code, input int edge_n);
    ev_t e;
    e.dut = d; e.kind = k; e.code = code; e.edge_n = edge_n;
    exp_q.push_back(e);
  endfunction

  function automatic void check_pulse(input int d, input logic kv, input logic kr,
                                      input logic me, input logic [3:0] code);
    ev_t      e;
    ev_kind_t k;
    if (kv || kr || me) begin
      check($sformatf("pulse_exclusive_d%0d", d), int'(kv) + int'(kr) + int'(me), 1);
      k = kv ? EV_VALID : (kr ? EV_REPEAT : EV_MERR);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: dut %0d kind %0d code %0d captured at edge %0d, required no pulse",
                 d, int'(k), code, cyc + 1);
      end else begin
        e = exp_q.pop_front();
        check("pulse_dut", d, e.dut);
        check("pulse_kind", int'(k), int'(e.kind));
        check("pulse_code", int'(code), e.code);
        check("pulse_edge", cyc + 1, e.edge_n);
      end
    end
  endfunction

  task automatic monitor_loop();
    forever begin
      @(negedge CLK);
      check_pulse(0, kv_a, kr_a, me_a, code_a);
      check_pulse(1, kv_b, kr_b, me_b, code_b);
      if (watch_idle && !idle_a) idle_drops++;
    end
  endtask

  function automatic logic held(input int d);
    return (d == 0) ? kh_a : kh_b;
  endfunction

  // Press one key so that row is low on h consecutive sampling edges,
  // starting at edge e0. Expected pulses come from the timing rules:
  // acceptance is captured D+2C+1 edges after e0, and repeats follow every
  // REPEAT_DELAY + n*REPEAT_RATE HOLD cycles while the key is still down.
  task automatic press_single(input int d, input int r, input int c, input int h);
    int   e0, rd, code, hold_cycles;
    logic acc;
    rd = (d == 0) ? RD : 0;
    code = r * C + c;
    @(negedge CLK);
    e0 = cyc + 1;
    acc = (h >= D + 2 * C + 2);
    if (acc) begin
      push_ev(d, EV_VALID, code, e0 + D + 2 * C + 1);
      if (d == 0) last_code_a = code;
      hold_cycles = h - D - 2 * C - 1;
      if (rd > 0)
        for (int k = rd; k <= hold_cycles; k += RR)
          push_ev(d, EV_REPEAT, code, e0 + D + 2 * C + k + 1);
    end
    if (d == 0) press_a[r*C+c] = 1'b1;
    else        press_b[r*C+c] = 1'b1;
    repeat (h) @(posedge CLK);
    @(negedge CLK);
    check("held_before_release", int'(held(d)), int'(acc));
    if (d == 0) press_a = '0;
    else        press_b = '0;
    @(negedge CLK);
    check("held_after_release", int'(held(d)), 0);
  endtask

  initial begin
    int e0, r, c, h;
    fork
      monitor_loop();
    join_none

    // Reset values
    anti_shake_cnt_reset = 1'b1;
    #1;
    check("rst_col", int'(col_a), 0);
    check("rst_code", int'(code_a), 15);
    check("rst_pulses", int'({kv_a, kr_a, me_a}), 0);
    check("rst_held", int'(kh_a), 0);
    check("rst_idle", int'(idle_a), 1);
    check("rst_b_code", int'(code_b), 15);
    check("rst_b_col", int'(col_b), 0);
    repeat (3) @(negedge CLK);
    anti_shake_cnt_reset = 1'b0;
    repeat (3) @(negedge CLK);

    // 1: single key (r2,c1), visible only through column 1
    press_single(0, 2, 1, 200);
    repeat (D + 10) @(negedge CLK);
    check("t1_code", int'(code_a), 9);
    check("t1_idle", int'(idle_a), 1);
    check("t1_drained", exp_q.size(), 0);

    // 2: bouncing contact never reaches the scan
    watch_idle = 1'b1;
    for (int i = 0; i < 5; i++) begin
      press_single(0, 1, 1, 10);
      repeat (2) @(negedge CLK);
    end
    repeat (D + 5) @(negedge CLK);
    watch_idle = 1'b0;
    check("t2_idle_never_dropped", idle_drops, 0);
    check("t2_code_kept", int'(code_a), 9);
    check("t2_drained", exp_q.size(), 0);

    // 3: long hold with auto-repeat
    press_single(0, 0, 3, 2500);
    repeat (D + 10) @(negedge CLK);
    check("t3_code", int'(code_a), 3);
    check("t3_drained", exp_q.size(), 0);

    // 4: two keys on row 1 -> ghost rejection
    @(negedge CLK);
    e0 = cyc + 1;
    push_ev(0, EV_MERR, last_code_a, e0 + D + 2 * C + 1);
    press_a[1*C+0] = 1'b1;
    press_a[1*C+2] = 1'b1;
    repeat (100) @(posedge CLK);
    @(negedge CLK);
    check("t4_held", int'(kh_a), 0);
    check("t4_idle_busy", int'(idle_a), 0);
    press_a = '0;
    repeat (D - 1) @(negedge CLK);
    check("t4_idle_before_debounce", int'(idle_a), 0);
    @(negedge CLK);
    check("t4_idle_after_debounce", int'(idle_a), 1);
    check("t4_code_kept", int'(code_a), last_code_a);
    check("t4_drained", exp_q.size(), 0);
    repeat (5) @(negedge CLK);

    // 5: reset while a key is held
    @(negedge CLK);
    e0 = cyc + 1;
    push_ev(0, EV_VALID, 14, e0 + D + 2 * C + 1);
    press_a[3*C+2] = 1'b1;
    repeat (D + 2 * C + 50) @(posedge CLK);
    @(negedge CLK);
    check("t5_held_pre", int'(kh_a), 1);
    #2 anti_shake_cnt_reset = 1'b1;
    #1;
    check("t5_rst_col", int'(col_a), 0);
    check("t5_rst_held", int'(kh_a), 0);
    check("t5_rst_code", int'(code_a), 15);
    check("t5_rst_idle", int'(idle_a), 1);
    @(negedge CLK);
    anti_shake_cnt_reset = 1'b0;
    e0 = cyc + 1;
    push_ev(0, EV_VALID, 14, e0 + D + 2 * C + 1);
    last_code_a = 14;
    repeat (D + 2 * C + 40) @(posedge CLK);
    @(negedge CLK);
    check("t5_held_post", int'(kh_a), 1);
    check("t5_code_post", int'(code_a), 14);
    press_a = '0;
    repeat (D + 10) @(negedge CLK);
    check("t5_drained", exp_q.size(), 0);

    // Randomized single presses: bounces and accepted holds
    for (int i = 0; i < 8; i++) begin
      r = $urandom_range(0, R - 1);
      c = $urandom_range(0, C - 1);
      if ($urandom_range(0, 3) == 0) h = $urandom_range(1, D);
      else                           h = $urandom_range(D + 2 * C + 2, 300);
      press_single(0, r, c, h);
      repeat (D + $urandom_range(5, 15)) @(negedge CLK);
      check("rand_idle", int'(idle_a), 1);
      check("rand_code", int'(code_a), last_code_a);
    end
    check("rand_drained", exp_q.size(), 0);

    // 6: 3x4 instance without auto-repeat
    press_single(1, 2, 3, 3000);
    repeat (D + 10) @(negedge CLK);
    check("t6_code", int'(code_b), 11);
    check("t6_idle", int'(idle_b), 1);
    check("t6_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
